// File: rtl/hazard_ctl_if.sv
// Bus between decode/datapath and hazard_ctl: ID instruction, back-end instruction
// window, external stall sources, and the stall/valid/forwarding controls driven back.
interface hazard_ctl_if #(
    parameter int DEPTH = 3
);
    localparam int SW = $clog2(DEPTH);

    // The ID instruction issues on an edge where id_vld = 1 and stall_id = 0;
    // while stall_id is high, decode must hold ir_id and id_vld unchanged.
    logic [31:0]         ir_id;
    logic                id_vld;
    logic [32*DEPTH-1:0] ir_be;
    logic                stall_imem;
    logic                stall_dmem;
    logic                amo_req;
    logic                amo_ack;
    logic                stall_if;
    logic                stall_pd;
    logic                stall_id;
    logic                stall_be;
    logic [DEPTH-1:0]    be_vld;
    logic                fw_a;
    logic                fw_b;
    logic [SW-1:0]       fw_a_sel;
    logic [SW-1:0]       fw_b_sel;
    logic [31:0]         perf_stall;

    modport master (
        output ir_id, id_vld, ir_be, stall_imem, stall_dmem, amo_req, amo_ack,
        input  stall_if, stall_pd, stall_id, stall_be, be_vld,
        input  fw_a, fw_b, fw_a_sel, fw_b_sel, perf_stall
    );

    modport slave (
        input  ir_id, id_vld, ir_be, stall_imem, stall_dmem, amo_req, amo_ack,
        output stall_if, stall_pd, stall_id, stall_be, be_vld,
        output fw_a, fw_b, fw_a_sel, fw_b_sel, perf_stall
    );
endinterface

// File: rtl/hazard_ctl.sv
// Hazard controller: compares the ID instruction with DEPTH back-end producers, forwards or
// interlocks, tracks bubbles and counts hazard stalls. Define HAZARD_FW_EN to enable forwarding.
module hazard_ctl #(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    hazard_ctl_if.slave bus
);
    localparam int SW = $clog2(DEPTH);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [DEPTH-1:0]      r_be_vld;
    logic [31:0]           r_perf;

    logic [6:0]            w_id_op;
    logic [4:0]            w_rs1;
    logic [4:0]            w_rs2;
    logic                  w_use_rs1;
    logic                  w_use_rs2;
    logic                  w_unused_id;
    logic                  w_stall_all;
    logic                  w_stall_id;
    logic                  w_dh;
    logic [DEPTH-1:0]      w_wr;
    logic [DEPTH-1:0][4:0] w_rd;
    logic                  w_a_hit;
    logic                  w_b_hit;
`ifdef HAZARD_FW_EN
    logic [DEPTH-1:0]      w_rdy;
    logic [SW-1:0]         w_a_k;
    logic [SW-1:0]         w_b_k;
    logic                  w_a_rdy;
    logic                  w_b_rdy;
    logic                  w_early;
`endif

    for (genvar k = 0; k < DEPTH; k++) begin : g_prod
        logic [31:0] w_ir;
        logic [6:0]  w_op;
        logic        w_unused_bits;
        assign w_ir          = bus.ir_be[32*k +: 32];
        assign w_op          = w_ir[6:0];
        assign w_rd[k]       = w_ir[11:7];
        assign w_unused_bits = ^w_ir[31:12];
        assign w_wr[k]       = r_be_vld[k] && (w_op != OP_BRANCH) && (w_op != OP_STORE)
                               && (w_rd[k] != 5'd0);
`ifdef HAZARD_FW_EN
        localparam bit LAT_OK = (k >= LOAD_LAT);
        assign w_rdy[k] = !((w_op == OP_LOAD) || (w_op == OP_SYSTEM)) || LAT_OK;
`endif
    end

    assign w_id_op     = bus.ir_id[6:0];
    assign w_rs1       = bus.ir_id[19:15];
    assign w_rs2       = bus.ir_id[24:20];
    assign w_unused_id = ^{bus.ir_id[31:25], bus.ir_id[14:7]};
    assign w_use_rs1   = bus.id_vld && (w_id_op != OP_LUI) && (w_id_op != OP_AUIPC)
                         && (w_id_op != OP_JAL);
    assign w_use_rs2   = bus.id_vld && ((w_id_op == OP_OP) || (w_id_op == OP_OP32)
                         || (w_id_op == OP_BRANCH) || (w_id_op == OP_STORE));

    // Scan oldest to youngest so the smallest matching stage index wins.
    always_comb begin
        w_a_hit = 1'b0;
        w_b_hit = 1'b0;
`ifdef HAZARD_FW_EN
        w_a_k   = '0;
        w_b_k   = '0;
        w_a_rdy = 1'b0;
        w_b_rdy = 1'b0;
`endif
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (w_use_rs1 && w_wr[k] && (w_rd[k] == w_rs1)) begin
                w_a_hit = 1'b1;
`ifdef HAZARD_FW_EN
                w_a_k   = SW'(k);
                w_a_rdy = w_rdy[k];
`endif
            end
            if (w_use_rs2 && w_wr[k] && (w_rd[k] == w_rs2)) begin
                w_b_hit = 1'b1;
`ifdef HAZARD_FW_EN
                w_b_k   = SW'(k);
                w_b_rdy = w_rdy[k];
`endif
            end
        end
    end

`ifdef HAZARD_FW_EN
    // Branch, jalr and store read operands before EX, so any match interlocks.
    assign w_early = (w_id_op == OP_BRANCH) || (w_id_op == OP_JALR) || (w_id_op == OP_STORE);
    assign w_dh    = (w_a_hit && (!w_a_rdy || w_early)) || (w_b_hit && (!w_b_rdy || w_early));
`else
    assign w_dh = w_a_hit || w_b_hit;
`endif

    assign w_stall_all  = !rst_n || bus.stall_imem || bus.stall_dmem
                          || (bus.amo_req && !bus.amo_ack);
    assign w_stall_id   = w_stall_all || w_dh;
    assign bus.stall_id = w_stall_id;
    assign bus.stall_pd = w_stall_id;
    assign bus.stall_if = w_stall_id || bus.amo_req;
    assign bus.stall_be = w_stall_all;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_be_vld <= '0;
            r_perf   <= '0;
        end else if (!w_stall_all) begin
            r_be_vld <= {r_be_vld[DEPTH-2:0], bus.id_vld && !w_dh};
            if (w_dh) r_perf <= r_perf + 32'd1;
        end
    end

    assign bus.be_vld     = r_be_vld;
    assign bus.perf_stall = r_perf;

`ifdef HAZARD_FW_EN
    logic          r_fw_a;
    logic          r_fw_b;
    logic [SW-1:0] r_fw_a_sel;
    logic [SW-1:0] r_fw_b_sel;

    // Selects keep their last value when forwarding is not used.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fw_a     <= 1'b0;
            r_fw_b     <= 1'b0;
            r_fw_a_sel <= '0;
            r_fw_b_sel <= '0;
        end else if (!w_stall_all) begin
            r_fw_a <= !w_dh && w_a_hit && w_a_rdy;
            r_fw_b <= !w_dh && w_b_hit && w_b_rdy;
            if (!w_dh && w_a_hit && w_a_rdy) r_fw_a_sel <= w_a_k;
            if (!w_dh && w_b_hit && w_b_rdy) r_fw_b_sel <= w_b_k;
        end
    end

    assign bus.fw_a     = r_fw_a;
    assign bus.fw_b     = r_fw_b;
    assign bus.fw_a_sel = r_fw_a_sel;
    assign bus.fw_b_sel = r_fw_b_sel;
`else
    localparam int unused_load_lat = LOAD_LAT;
    assign bus.fw_a     = 1'b0;
    assign bus.fw_b     = 1'b0;
    assign bus.fw_a_sel = '0;
    assign bus.fw_b_sel = '0;
`endif
endmodule

// File: tb/tb_hazard_ctl.sv
// Bench for hazard_ctl: directed hazard scenarios then randomized traffic, all checked
// against an instruction-level reference model of the back-end window.
module tb_hazard_ctl;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 2;
`ifdef HAZARD_FW_EN
  localparam bit FW = 1'b1;
`else
  localparam bit FW = 1'b0;
`endif

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPS [11] = '{OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR, OP_JAL,
                                      OP_LUI, OP_AUIPC, OP_OP, OP_OP32, OP_SYSTEM};

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  hazard_ctl_if #(.DEPTH(DEPTH)) bus ();
  hazard_ctl #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: instruction window of the back end
  logic [31:0] m_ir [DEPTH];
  bit          m_vld [DEPTH];
  bit          m_fw_a, m_fw_b;
  int          m_fw_a_sel, m_fw_b_sel;
  logic [31:0] m_perf;
  bit          m_issued, m_stall_id;

  function automatic bit writes(int k);
    logic [6:0] op;
    op = m_ir[k][6:0];
    return m_vld[k] && !(op inside {OP_BRANCH, OP_STORE}) && (m_ir[k][11:7] != 5'd0);
  endfunction

  function automatic bit prod_ready(int k);
    logic [6:0] op;
    op = m_ir[k][6:0];
    return !(op inside {OP_LOAD, OP_SYSTEM}) || (k >= LOAD_LAT);
  endfunction

  function automatic int youngest(logic [4:0] rs);
    for (int k = 0; k < DEPTH; k++)
      if (writes(k) && m_ir[k][11:7] == rs) return k;
    return -1;
  endfunction

  task automatic model_hazard(output bit dh, output int ka, output int kb);
    logic [31:0] ir;
    logic [6:0]  op;
    bit          early;
    ir = bus.ir_id;
    op = ir[6:0];
    ka = (bus.id_vld && !(op inside {OP_LUI, OP_AUIPC, OP_JAL})) ? youngest(ir[19:15]) : -1;
    kb = (bus.id_vld && (op inside {OP_OP, OP_OP32, OP_BRANCH, OP_STORE})) ? youngest(ir[24:20]) : -1;
    early = op inside {OP_BRANCH, OP_JALR, OP_STORE};
    if (FW) dh = (ka >= 0 && (early || !prod_ready(ka))) || (kb >= 0 && (early || !prod_ready(kb)));
    else    dh = (ka >= 0) || (kb >= 0);
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_be();
    for (int k = 0; k < DEPTH; k++) bus.ir_be[32*k +: 32] = m_ir[k];
  endtask

  // one clock: entered and left at posedge+1
  task automatic cycle();
    bit sa, dh;
    int ka, kb;
    logic [DEPTH-1:0] v;
    drive_be();
    #3;
    sa = !rst_n || bus.stall_imem || bus.stall_dmem || (bus.amo_req && !bus.amo_ack);
    model_hazard(dh, ka, kb);
    chk("stall_id", bus.stall_id, sa || dh);
    chk("stall_pd", bus.stall_pd, sa || dh);
    chk("stall_if", bus.stall_if, sa || dh || bus.amo_req);
    chk("stall_be", bus.stall_be, sa);
    m_stall_id = sa || dh;
    m_issued   = !sa && !dh && bus.id_vld;
    @(posedge clk);
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) m_vld[k] = 1'b0;
      m_fw_a = 0; m_fw_b = 0; m_fw_a_sel = 0; m_fw_b_sel = 0; m_perf = '0;
    end else if (!sa) begin
      m_fw_a = FW && !dh && ka >= 0 && prod_ready(ka);
      m_fw_b = FW && !dh && kb >= 0 && prod_ready(kb);
      if (m_fw_a) m_fw_a_sel = ka;
      if (m_fw_b) m_fw_b_sel = kb;
      if (dh) m_perf = m_perf + 32'd1;
      for (int k = DEPTH - 1; k > 0; k--) begin
        m_vld[k] = m_vld[k-1];
        m_ir[k]  = m_ir[k-1];
      end
      m_vld[0] = bus.id_vld && !dh;
      m_ir[0]  = bus.ir_id;
    end
    #1;
    drive_be();
    for (int k = 0; k < DEPTH; k++) v[k] = m_vld[k];
    chk("be_vld", bus.be_vld, v);
    chk("fw_a", bus.fw_a, m_fw_a);
    chk("fw_b", bus.fw_b, m_fw_b);
    chk("fw_a_sel", bus.fw_a_sel, m_fw_a_sel);
    chk("fw_b_sel", bus.fw_b_sel, m_fw_b_sel);
    chk("perf_stall", bus.perf_stall, m_perf);
  endtask

  // driver tasks
  function automatic logic [31:0] mk_r(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b0, rd, op};
  endfunction

  function automatic logic [31:0] mk_i(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
    return {imm, rs1, 3'b0, rd, op};
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [31:0] ir;
    ir = $urandom;
    ir[6:0]   = OPS[$urandom_range(0, 10)];
    ir[11:7]  = 5'($urandom_range(0, 3));
    ir[19:15] = 5'($urandom_range(0, 3));
    ir[24:20] = 5'($urandom_range(0, 3));
    return ir;
  endfunction

  task automatic drain();
    bus.id_vld = 1'b0;
    repeat (DEPTH + 1) cycle();
  endtask

  // hold ir in ID until it issues; optional 4-cycle dmem miss starting at cycle miss_at
  task automatic issue(input logic [31:0] ir, input int miss_at, output int n_stall);
    n_stall = 0;
    bus.ir_id  = ir;
    bus.id_vld = 1'b1;
    for (int i = 0; i < 24; i++) begin
      bus.stall_dmem = (miss_at >= 0) && (i >= miss_at) && (i < miss_at + 4);
      cycle();
      if (m_issued) break;
      n_stall++;
    end
    bus.stall_dmem = 1'b0;
    bus.id_vld     = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] base;
    rst_n = 1'b0;
    bus.ir_id = '0; bus.id_vld = 1'b0; bus.ir_be = '0;
    bus.stall_imem = 1'b0; bus.stall_dmem = 1'b0; bus.amo_req = 1'b0; bus.amo_ack = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin m_ir[k] = '0; m_vld[k] = 1'b0; end
    m_fw_a = 0; m_fw_b = 0; m_fw_a_sel = 0; m_fw_b_sel = 0; m_perf = '0;
    m_issued = 0; m_stall_id = 1;
    @(posedge clk); #1;

    // reset values
    cycle(); cycle();
    chk("rst_be_vld", bus.be_vld, 0);
    chk("rst_perf", bus.perf_stall, 0);
    chk("rst_stall_if", bus.stall_if, 1);
    rst_n = 1'b1;
    drain();

    // ALU back-to-back (macro off: 3 interlock cycles)
    base = m_perf;
    issue(mk_i(OP_IMM, 5, 0, 12'd1), -1, n);
    issue(mk_r(OP_OP, 6, 5, 7), -1, n);
    chk("b2b_stalls", n, FW ? 0 : 3);
    chk("b2b_fw_a", bus.fw_a, FW);
    chk("b2b_fw_a_sel", bus.fw_a_sel, 0);
    chk("b2b_fw_b", bus.fw_b, 0);
    chk("b2b_perf", bus.perf_stall, base + (FW ? 2'd0 : 2'd3));

    // load-use
    drain();
    base = m_perf;
    issue(mk_i(OP_LOAD, 5, 1, 12'd0), -1, n);
    issue(mk_r(OP_OP, 6, 5, 7), -1, n);
    chk("ld_stalls", n, FW ? 2 : 3);
    chk("ld_fw_a", bus.fw_a, FW);
    chk("ld_fw_a_sel", bus.fw_a_sel, FW ? 2 : 0);
    chk("ld_perf", bus.perf_stall, base + (FW ? 2'd2 : 2'd3));

    // x0 destination never matches
    drain();
    issue(mk_i(OP_IMM, 0, 0, 12'd1), -1, n);
    issue(mk_i(OP_IMM, 6, 0, 12'd1), -1, n);
    chk("x0_stalls", n, 0);
    chk("x0_fw_a", bus.fw_a, 0);

    // I-type immediate bits overlapping rs2 field are not an operand
    drain();
    issue(mk_i(OP_IMM, 5, 0, 12'd1), -1, n);
    issue(mk_i(OP_IMM, 6, 1, 12'd5), -1, n);
    chk("rs2_stalls", n, 0);
    chk("rs2_fw_b", bus.fw_b, 0);
    chk("rs2_fw_a", bus.fw_a, 0);

    // rs1 and rs2 matched at different stages
    drain();
    issue(mk_i(OP_IMM, 5, 0, 12'd1), -1, n);
    issue(mk_i(OP_IMM, 7, 0, 12'd2), -1, n);
    issue(mk_r(OP_OP, 6, 5, 7), -1, n);
    chk("dual_stalls", n, FW ? 0 : 3);
    chk("dual_fw_a", bus.fw_a, FW);
    chk("dual_fw_b", bus.fw_b, FW);
    chk("dual_fw_a_sel", bus.fw_a_sel, FW ? 1 : 0);
    chk("dual_fw_b_sel", bus.fw_b_sel, 0);

    // branch resolves early: always interlocks on a match
    drain();
    issue(mk_i(OP_IMM, 5, 0, 12'd1), -1, n);
    issue(mk_r(OP_BRANCH, 5'd0, 5, 0), -1, n);
    chk("br_stalls", n, 3);

    // dmem miss during a load-use interlock
    drain();
    base = m_perf;
    issue(mk_i(OP_LOAD, 5, 1, 12'd0), -1, n);
    issue(mk_r(OP_OP, 6, 5, 7), 1, n);
    chk("miss_cycles", n, FW ? 6 : 7);
    chk("miss_perf", bus.perf_stall, base + (FW ? 2'd2 : 2'd3));

    // reset during an interlock
    drain();
    issue(mk_i(OP_LOAD, 5, 1, 12'd0), -1, n);
    bus.ir_id  = mk_r(OP_OP, 6, 5, 7);
    bus.id_vld = 1'b1;
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("rstmid_be_vld", bus.be_vld, 0);
    chk("rstmid_fw_a", bus.fw_a, 0);
    chk("rstmid_fw_b", bus.fw_b, 0);
    chk("rstmid_perf", bus.perf_stall, 0);
    #1;
    chk("rstmid_stall_id", bus.stall_id, 0);
    issue(mk_r(OP_OP, 6, 5, 7), -1, n);
    chk("rstmid_stalls", n, 0);

    // randomized traffic; ID holds its instruction while stalled
    for (int c = 0; c < 800; c++) begin
      if (!m_stall_id) begin
        bus.ir_id  = rand_ir();
        bus.id_vld = ($urandom_range(0, 9) < 8);
      end
      bus.stall_imem = ($urandom_range(0, 19) == 0);
      bus.stall_dmem = ($urandom_range(0, 19) == 0);
      bus.amo_req    = ($urandom_range(0, 24) == 0);
      bus.amo_ack    = ($urandom_range(0, 1) == 0);
      rst_n          = ($urandom_range(0, 199) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctl.md
# hazard_ctl

Parametrised pipeline hazard controller for the in-order core: a successor to the fixed three-stage control unit. It sits between decode and the back-end datapath and compares the ID-stage instruction against a configurable number of back-end producer stages. Per cycle it decides between forwarding and interlocking, inserts tracked bubbles, and drives registered forwarding selects and stage stalls. It also adds operand-accurate rs2 usage, a parametrised load latency and a hazard-stall performance counter.

## Interface
- DEPTH, 3: back-end producer stages after ID, with stage 0 = EX and stage DEPTH-1 = WB; minimum 2. SW = $clog2(DEPTH).
- LOAD_LAT, 2: first stage index where load/system results are forwardable; range 0..DEPTH-1.
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- ir_id  in  32  instruction in ID
- id_vld  in  1  ID holds a real instruction
- ir_be  in  32*DEPTH  back-end instructions; stage k at bits [32k+31:32k]
- stall_imem, stall_dmem  in  1  cache-miss stalls
- amo_req, amo_ack  in  1  atomic request/acknowledge
- stall_if, stall_pd, stall_id  out  1  front-end stalls
- stall_be  out  1  freeze all back-end stages
- be_vld  out  DEPTH  per-stage valid, where 0 = bubble
- fw_a, fw_b  out  1  forward enable for operands A and B
- fw_a_sel, fw_b_sel  out  SW  forwarding source stage index
- perf_stall  out  32  count of hazard-stall cycles

## Operation
- stall_all = !rst_n | stall_imem | stall_dmem | (amo_req & !amo_ack).
- Producer k (P_k):
  - P_k writes iff be_vld[k], opcode is not branch/store, and rd != 0.
  - P_k is ready iff its opcode is ALU-class, or it is load/system and k >= LOAD_LAT.
- Consumer operands:
  - rs1 is used unless the opcode is lui, auipc or jal.
  - rs2 is used only for rtype, rtype_w, branch and store.
  - An operand is not checked when id_vld = 0.
- Match: for each used operand, the smallest k whose P_k writes rd == rs wins (youngest producer).
- Hazard dh:
  - With forwarding, dh is set if any used operand's youngest match is not ready.
  - Also with forwarding, dh is set if the consumer is branch, jalr or store and has any match. These resolve early and always interlock.
  - Without forwarding, dh is set if any used operand has any match.
- Stall derivation:
  - stall_id = stall_pd = stall_all | dh.
  - stall_if = stall_id | amo_req.
  - stall_be = stall_all. Hazards never freeze the back end; bubbles are inserted instead.
- be_vld shift: on an edge with !stall_all, be_vld <= {be_vld[DEPTH-2:0], id_vld & !dh}.
- Stall length is not latched. dh is re-evaluated every cycle as producers advance and bubbles fill stage 0. The result is (LOAD_LAT - k) stall cycles for a load matched at stage k, and (DEPTH - k) cycles without forwarding.
- Forwarding registers, updated on an edge with !stall_all:
  - When the operand issues (!dh) and its youngest match is ready: fw_x <= 1 and fw_x_sel <= k.
  - Otherwise: fw_x <= 0, and fw_x_sel holds its value.
- perf_stall increments on an edge with dh & !stall_all. It wraps modulo 2^32.

## Timing
- stall_* and dh are combinational from the inputs and be_vld; there is no added latency.
- fw_*, fw_*_sel, be_vld and perf_stall are registered. fw_* apply to the instruction that enters EX on the same edge.
- Reset values: be_vld = 0, fw_a = fw_b = 0, fw_a_sel = fw_b_sel = 0, perf_stall = 0.
- During reset every stall output is 1, because rst_n = 0 forces stall_all.
- While stall_all is high, all registers hold. A hazard seen during stall_all does not count.
- Reset mid-interlock: all state clears on the next edge, and the interlock is not resumed.
- amo_req without amo_ack freezes the whole pipe. On amo_ack, stall_if stays high while amo_req stays high.
- Simultaneous match on rs1 and rs2 with different k: each operand is evaluated independently, and dh is the OR of both.

## Configuration
- HAZARD_FW_EN defined: forwarding enabled as described above.
- HAZARD_FW_EN undefined:
  - fw_a, fw_b and both selects are tied to 0.
  - Ready logic is dropped, and every match interlocks until the producer leaves stage DEPTH-1.

## Test plan
- **ALU back-to-back:** `addi x5` valid in EX, ID = `add x6,x5,x7` -> dh = 0, and next edge fw_a = 1, fw_a_sel = 0, fw_b = 0.
- **Load-use, LOAD_LAT = 2:** `lw x5` in EX, ID uses x5 -> stall_id high for 2 cycles, be_vld[0] = 0 twice, then fw_a = 1 with fw_a_sel = 2; perf_stall = 2.
- **x0 destination and rs2 usage:**
  - `addi x0` in EX with ID rs1 = x0 -> no stall and fw_a = 0.
  - An I-type whose bits [24:20] equal an EX rd -> no stall and fw_b = 0.
- **Macro off, DEPTH = 3:** ALU producer in EX, consumer in ID -> 3 stall cycles, and fw_* stays 0.
- **Miss during interlock:** stall_dmem pulses 4 cycles during a load-use stall -> be_vld and perf_stall hold, and the total hazard-stall count is still 2.
- **Reset mid-stall:** rst_n low for 1 edge during an interlock -> be_vld = 0, fw = 0, perf_stall = 0, and no residual stall after release.
